// File: rtl/apb_pkg.sv
// Shared APB master definitions: transfer phase encoding, default bus widths,
// and the default-width command record.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. On a tie the grant goes to the requester that was
// not granted last; last_grant only moves when the caller says the grant was used.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_reg;

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant_reg ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Reset value 1 makes requester 0 the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_grant_reg <= grant[1];
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin command acceptance, SETUP/ACCESS transfer
// on a shared APB bus, and a one-cycle response with read data or timeout error.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  apb_state_t        state_reg, state_next;
  cmd_t              cmd_reg;
  logic              gidx_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [1:0]        rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_err_reg;

  logic [1:0] grant;
  logic       gsel;
  logic       accept;
  logic       done;
  logic       timed_out;

  assign accept = (state_reg == IDLE) && (req_valid != 2'b00);
  assign gsel   = grant[1];

  rr_arb2 u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Held low during reset even though state already reads IDLE.
  assign req_ready = (PRESETn && (state_reg == IDLE)) ? grant : 2'b00;

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state_reg)
      IDLE:   if (accept) state_next = SETUP;
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done = 1'b1;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cmd_reg  <= '0;
      gidx_reg <= 1'b0;
    end else if (accept) begin
      gidx_reg      <= gsel;
      cmd_reg.write <= req_write[gsel];
      cmd_reg.addr  <= req_addr[gsel*ADDR_W +: ADDR_W];
      cmd_reg.wdata <= req_wdata[gsel*DATA_W +: DATA_W];
    end
  end

  // Counts completed ACCESS cycles without PREADY; cleared whenever not waiting.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_reg <= '0;
    end else if ((state_reg == ACCESS) && !done) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else begin
      cnt_reg <= '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_reg <= 2'b00;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 2'b00;
      if (done) begin
        rsp_valid_reg <= gidx_reg ? 2'b10 : 2'b01;
        rsp_err_reg   <= timed_out;
        rsp_rdata_reg <= (cmd_reg.write || timed_out) ? '0 : PRDATA;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  assign PSEL    = (state_reg != IDLE);
  assign PENABLE = (state_reg == ACCESS);
  assign PWRITE  = cmd_reg.write;
  assign PADDR   = cmd_reg.addr;
  assign PWDATA  = cmd_reg.wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed vector table, reset and
// contention sequences, then random traffic against a transaction-level model.
module tb_apb_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [1:0]    req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY;

  int checks = 0;
  int errors = 0;
  int m_last = 1;
  int grant_q[$];

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] prdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bit          b2b;
  } vec_t;

  vec_t vecs[7];

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge PCLK);
    #2;
  endtask

  task automatic drive_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return r;
    if (r == 6) return 15;
    if (r == 7) return 16;
    if (r == 8) return 20;
    return 1;
  endfunction

  // One isolated transfer; starts driving in the current cycle, ends after the response cycle.
  task automatic run_txn(input vec_t v, input string nm);
    logic [1:0] oh;
    int n_acc;
    oh = (v.idx == 0) ? 2'b01 : 2'b10;
    n_acc = (v.delay < TO) ? v.delay + 1 : TO;
    req_valid = oh;
    drive_req(v.idx, v.wr, v.addr, v.wdata);
    drive_req(1 - v.idx, $urandom_range(0, 1), $urandom, $urandom);
    PREADY = 1'b1;
    #1;
    chk({nm, "_ready"}, req_ready, oh);
    chk({nm, "_idle_psel"}, PSEL, 1'b0);
    nxt();
    req_valid = 2'b00;
    drive_req(v.idx, $urandom_range(0, 1), $urandom, $urandom);
    PREADY = 1'b1;
    #1;
    chk({nm, "_setup_ctl"}, {PSEL, PENABLE}, 2'b10);
    chk({nm, "_setup_addr"}, PADDR, v.addr);
    chk({nm, "_setup_wdata"}, PWDATA, v.wdata);
    chk({nm, "_setup_write"}, PWRITE, v.wr);
    chk({nm, "_setup_rsp"}, rsp_valid, 2'b00);
    for (int k = 0; k < n_acc; k++) begin
      nxt();
      PREADY = (k == v.delay);
      PRDATA = (k == v.delay) ? v.prdata : $urandom;
      #1;
      chk($sformatf("%s_acc%0d_ctl", nm, k), {PSEL, PENABLE}, 2'b11);
      chk($sformatf("%s_acc%0d_addr", nm, k), PADDR, v.addr);
      chk($sformatf("%s_acc%0d_wdata", nm, k), PWDATA, v.wdata);
      chk($sformatf("%s_acc%0d_rsp", nm, k), rsp_valid, 2'b00);
    end
    nxt();
    PREADY = 1'b0;
    PRDATA = $urandom;
    #1;
    chk({nm, "_rsp_psel"}, PSEL, 1'b0);
    chk({nm, "_rsp_valid"}, rsp_valid, oh);
    chk({nm, "_rsp_err"}, rsp_err, v.exp_err);
    chk({nm, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    $display("txn %s req%0d %s addr=%h err=%0b rdata=%h", nm, v.idx, v.wr ? "WR" : "RD",
             v.addr, rsp_err, rsp_rdata);
  endtask

  // Transaction-level reference: tracks pending commands per requester, the last
  // winner, and the APB phase the bus must show; checks every cycle.
  task automatic run_model(input int per_req, input bit contention);
    bit rv[2];
    bit rwr[2];
    logic [31:0] raddr[2];
    logic [31:0] rwd[2];
    int issued[2];
    int ph, owner, acc_k, cur_delay, done_cnt, cyc, g;
    bit cwr, rp, rp_err;
    logic [31:0] caddr, cwd, prd, rp_rd;
    int rp_owner;
    logic [1:0] exp_rdy, exp_bus;
    ph = 0; owner = 0; acc_k = 0; cur_delay = 0; done_cnt = 0; cyc = 0;
    cwr = 0; caddr = 0; cwd = 0; rp = 0; rp_err = 0; rp_rd = 0; rp_owner = 0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; issued[i] = 0; rwr[i] = 0; raddr[i] = 0; rwd[i] = 0;
    end
    grant_q.delete();
    while ((done_cnt < 2 * per_req) || rp) begin
      if (cyc > per_req * 80 + 100) begin
        checks++;
        errors++;
        $display("FAIL model_cycle_budget: got %0d completions expected %0d", done_cnt, 2 * per_req);
        break;
      end
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && issued[i] < per_req && (contention || $urandom_range(0, 2) == 0)) begin
          rv[i] = 1; rwr[i] = 1'($urandom_range(0, 1)); raddr[i] = $urandom; rwd[i] = $urandom;
          issued[i]++;
        end
        req_valid[i] = rv[i];
        if (rv[i]) drive_req(i, rwr[i], raddr[i], rwd[i]);
        else drive_req(i, $urandom_range(0, 1), $urandom, $urandom);
      end
      PRDATA = $urandom;
      prd = PRDATA;
      PREADY = (ph == 2) ? (acc_k == cur_delay) : 1'($urandom_range(0, 1));
      #1;
      if (rp) begin
        chk("rnd_rsp_valid", rsp_valid, rp_owner ? 2'b10 : 2'b01);
        chk("rnd_rsp_err", rsp_err, rp_err);
        chk("rnd_rsp_rdata", rsp_rdata, rp_rd);
        $display("txn rnd req%0d err=%0b rdata=%h", rp_owner, rsp_err, rsp_rdata);
      end else begin
        chk("rnd_rsp_idle", rsp_valid, 2'b00);
      end
      rp = 0;
      exp_bus = (ph == 0) ? 2'b00 : (ph == 1) ? 2'b10 : 2'b11;
      chk("rnd_bus_phase", {PSEL, PENABLE}, exp_bus);
      if (ph != 0) begin
        chk("rnd_paddr", PADDR, caddr);
        chk("rnd_pwrite", PWRITE, cwr);
        chk("rnd_pwdata", PWDATA, cwd);
      end
      if (ph == 0) begin
        if (rv[0] && rv[1]) g = (m_last == 0) ? 1 : 0;
        else if (rv[0]) g = 0;
        else if (rv[1]) g = 1;
        else g = -1;
        exp_rdy = (g < 0) ? 2'b00 : (g == 1) ? 2'b10 : 2'b01;
        chk("rnd_req_ready", req_ready, exp_rdy);
        if (g >= 0) begin
          owner = g; m_last = g;
          cwr = rwr[g]; caddr = raddr[g]; cwd = rwd[g];
          rv[g] = 0;
          grant_q.push_back(g);
          cur_delay = contention ? 0 : pick_delay();
          ph = 1;
        end
      end else if (ph == 1) begin
        chk("rnd_ready_busy", req_ready, 2'b00);
        ph = 2;
        acc_k = 0;
      end else begin
        chk("rnd_ready_busy", req_ready, 2'b00);
        if (PREADY || acc_k == TO - 1) begin
          rp = 1; rp_owner = owner; rp_err = !PREADY;
          rp_rd = (!cwr && PREADY) ? prd : 32'h0;
          done_cnt++;
          ph = 0;
        end else begin
          acc_k++;
        end
      end
      cyc++;
      nxt();
    end
    req_valid = 2'b00;
    PREADY = 1'b0;
  endtask

  initial begin
    bit prev_b2b;
    vecs[0] = '{0, 1'b1, 32'h3,        32'hDEADBEEF, 0,  32'hAAAA5555, 1'b0, 32'h0,        1'b0};
    vecs[1] = '{1, 1'b0, 32'h5,        32'h0,        3,  32'h12345678, 1'b0, 32'h12345678, 1'b0};
    vecs[2] = '{0, 1'b0, 32'h100,      32'h0,        20, 32'hCAFEF00D, 1'b1, 32'h0,        1'b0};
    vecs[3] = '{1, 1'b0, 32'h104,      32'h0,        15, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE, 1'b0};
    vecs[4] = '{0, 1'b1, 32'hFFFFFFFC, 32'h01234567, 16, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[5] = '{0, 1'b0, 32'h20,       32'h0,        1,  32'h55AA55AA, 1'b0, 32'h55AA55AA, 1'b1};
    vecs[6] = '{0, 1'b1, 32'h24,       32'h600DF00D, 0,  32'h0,        1'b0, 32'h0,        1'b0};

    PRESETn = 1'b1;
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = '1; req_wdata = '1;
    PRDATA = '0; PREADY = 1'b0;
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    @(posedge PCLK);
    #3 PRESETn = 1'b1;
    req_valid = 2'b00;

    prev_b2b = 0;
    for (int v = 0; v < 7; v++) begin
      if (!prev_b2b) nxt();
      run_txn(vecs[v], $sformatf("vec%0d", v));
      prev_b2b = vecs[v].b2b;
    end

    // Reset asserted between edges while requester 0's transfer is in ACCESS.
    nxt();
    req_valid = 2'b01;
    drive_req(0, 1'b1, 32'h40, 32'h11112222);
    #1;
    chk("rstmid_accept", req_ready, 2'b01);
    nxt();
    req_valid = 2'b00;
    PREADY = 1'b0;
    nxt();
    nxt();
    #1;
    chk("rstmid_in_access", {PSEL, PENABLE}, 2'b11);
    req_valid = 2'b11;
    PRESETn = 1'b0;
    #1;
    chk("rstmid_ctl_drop", {PSEL, PENABLE}, 2'b00);
    chk("rstmid_rsp", rsp_valid, 2'b00);
    chk("rstmid_ready", req_ready, 2'b00);
    chk("rstmid_paddr", PADDR, 32'h0);
    @(posedge PCLK);
    #3;
    chk("rstmid_held_ctl", {PSEL, PENABLE}, 2'b00);
    chk("rstmid_held_ready", req_ready, 2'b00);
    PRESETn = 1'b1;
    req_valid = 2'b00;
    m_last = 1;
    nxt();
    chk("rstmid_no_rsp", rsp_valid, 2'b00);

    // Contention: both requesters continuously valid, four commands each.
    run_model(4, 1'b1);
    chk("cont_grant_count", grant_q.size(), 8);
    for (int j = 0; j < 8 && j < grant_q.size(); j++) begin
      chk($sformatf("cont_grant%0d", j), grant_q[j], j % 2);
    end

    // Random traffic with random slave latency, including timeouts.
    run_model(20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester APB master and arbiter. It accepts read/write commands from two on-chip requesters (e.g. a DMA engine and a control CPU port), grants them round-robin, and runs each command as a standard APB SETUP/ACCESS transfer on one shared APB bus toward the slave memories. It returns read data or a timeout error to the requester that issued the command.

## Interface
Parameters:
- ADDR_W, 32, PADDR and request address width
- DATA_W, 32, PWDATA/PRDATA and request data width
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before abort (≥2)

Ports:
- PCLK  in  1  single clock, all logic on rising edge
- PRESETn  in  1  reset, asynchronous assert, active-low
- req_valid  in  2  per-requester command valid; held until accepted
- req_write  in  2  per-requester 1=write, 0=read
- req_addr  in  2×ADDR_W  per-requester address, packed [i*ADDR_W +: ADDR_W]
- req_wdata  in  2×DATA_W  per-requester write data, packed
- req_ready  out  2  combinational accept pulse, one-hot, IDLE only
- rsp_valid  out  2  one-cycle response pulse to the issuing requester
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes and errors
- rsp_err  out  1  timeout flag, valid with rsp_valid
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, any req_valid: the grant is picked round-robin. If both requesters are valid, the grant goes to the one not granted last; last_grant resets to 1, so requester 0 wins first. req_ready[g]=1 in this cycle. On the edge, write/addr/wdata of g are latched and the FSM moves to SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latched command. Always exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1, bus fields held stable. The timeout counter increments each cycle.
  - PREADY=1: PRDATA is captured (reads only) and the FSM returns to IDLE.
  - Counter reaches TIMEOUT-1 with PREADY=0: the transfer is aborted, rsp_err is set and the FSM returns to IDLE.
- Response: the cycle after ACCESS completes, rsp_valid[g]=1 for one cycle with rsp_rdata/rsp_err. IDLE may accept a new command in that same cycle.
- Requester fields may change freely while req_valid=0 or after acceptance; they are not sampled at any other time.
- PSEL=0 in IDLE; PADDR/PWDATA hold their last values (no toggling).
- No write-data masking, no PSLVERR input. Errors come from timeout only.

## Timing
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, last_grant=1, counter=0. req_ready=0 while in reset.
- Minimum transaction, PREADY high at the first ACCESS cycle: accept (T0), SETUP (T1), ACCESS (T2), rsp_valid (T3). Throughput is one transfer per 3 cycles, since T3 is also IDLE.
- PREADY is ignored outside ACCESS.
- Timeout boundary: PREADY=1 on the TIMEOUT-th ACCESS cycle completes normally, with no error.
- Reset mid-transfer: all outputs go to reset values immediately. The aborted command gets no response, and the requester must reissue.
- Simultaneous requests are never both accepted. A request arriving during SETUP/ACCESS waits for IDLE.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS)
  - default ADDR_W/DATA_W
  - the APB command struct {write, addr, wdata}
- Sub-module rr_arb2: a 2-way round-robin grant with last_grant register, taking req[1:0] and advance, and producing a one-hot grant. It is reusable by other bus masters.
- Top module: FSM, command latch, timeout counter, response register.

## Test plan
- Single write: req0 write addr=3 data=0xDEADBEEF. Required: req_ready[0] at T0; PSEL=1/PENABLE=0 at T1; PENABLE=1 with PADDR=3 and PWDATA=0xDEADBEEF from T2 until PREADY; rsp_valid[0] with rsp_err=0 one cycle after PREADY.
- Single read with wait: req1 read addr=5, PREADY delayed 3 ACCESS cycles, PRDATA=0x12345678. Required: rsp_valid[1] with rsp_rdata=0x12345678 and bus fields stable throughout ACCESS.
- Contention: both valid continuously, 4 commands each. Required grant order 0,1,0,1,… with no starvation; every rsp_valid goes to the matching requester.
- Timeout: PREADY held 0, TIMEOUT=16. Required: exactly 16 ACCESS cycles, then PSEL=0, rsp_err=1 and rsp_rdata=0. A second run with PREADY=1 on the 16th cycle must give rsp_err=0.
- Reset mid-ACCESS: assert PRESETn=0 asynchronously between edges. Required: PSEL/PENABLE drop immediately, no rsp_valid; after release, req0 wins first grant.
- Back-to-back: req0 re-asserts valid during its rsp_valid cycle. Required: accepted in that cycle, next SETUP one cycle later.
